add_icb_arbiter: RTL and testbench

//  2-to-1 ICB arbiter that shares the single-slave adder peripheral (AUGEND/ADDEND/CTRL/SUM/OFSIGN

---
 rtl/add_icb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_add_icb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_icb_arbiter.sv
// add_icb_arbiter: 2-to-1 round-robin ICB arbiter in front of the adder register block.
// One transaction in flight at a time. The command is latched on master accept and replayed
// to the slave from a register. The response is steered combinationally to the granted master.
// Optional slave watchdog: define ADD_ARB_TIMEOUT_EN to add the counter, the ERR state and the
// orphan-response drop logic.
module add_icb_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // master 0
  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  output logic            m0_icb_rsp_err,
  // master 1
  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  output logic            m1_icb_rsp_err,
  // adder slave
  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic            s_icb_cmd_read,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic [DW-1:0]   s_icb_rsp_rdata,
  input  logic            s_icb_rsp_err
);

  localparam int MW = DW/8;

`ifdef ADD_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2, ERR = 2'd3} state_t;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2} state_t;
`endif

  state_t state, state_nxt;
  logic   last_grant;  // master served most recently; the other one wins a tie
  logic   grant;       // master owning the current transaction

  logic          lat_read;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [MW-1:0] lat_wmask;

  // per-master views as packed arrays so the datapath can be indexed by grant
  logic [1:0]         m_cmd_valid, m_cmd_read, m_cmd_ready;
  logic [1:0][AW-1:0] m_cmd_addr;
  logic [1:0][DW-1:0] m_cmd_wdata;
  logic [1:0][MW-1:0] m_cmd_wmask;
  logic [1:0]         m_rsp_valid, m_rsp_ready, m_rsp_err;
  logic [1:0][DW-1:0] m_rsp_rdata;

  assign m_cmd_valid = {m1_icb_cmd_valid, m0_icb_cmd_valid};
  assign m_cmd_read  = {m1_icb_cmd_read,  m0_icb_cmd_read};
  assign m_cmd_addr  = {m1_icb_cmd_addr,  m0_icb_cmd_addr};
  assign m_cmd_wdata = {m1_icb_cmd_wdata, m0_icb_cmd_wdata};
  assign m_cmd_wmask = {m1_icb_cmd_wmask, m0_icb_cmd_wmask};
  assign m_rsp_ready = {m1_icb_rsp_ready, m0_icb_rsp_ready};

  assign m0_icb_cmd_ready = m_cmd_ready[0];
  assign m1_icb_cmd_ready = m_cmd_ready[1];
  assign m0_icb_rsp_valid = m_rsp_valid[0];
  assign m1_icb_rsp_valid = m_rsp_valid[1];
  assign m0_icb_rsp_rdata = m_rsp_rdata[0];
  assign m1_icb_rsp_rdata = m_rsp_rdata[1];
  assign m0_icb_rsp_err   = m_rsp_err[0];
  assign m1_icb_rsp_err   = m_rsp_err[1];

  assign s_icb_cmd_read  = lat_read;
  assign s_icb_cmd_addr  = lat_addr;
  assign s_icb_cmd_wdata = lat_wdata;
  assign s_icb_cmd_wmask = lat_wmask;

  // watchdog and orphan flag exist only in the timeout build
  logic orphan;
  logic wd_hit;
`ifdef ADD_ARB_TIMEOUT_EN
  logic [15:0] wdog;
  logic [15:0] wdog_inc;
  assign wdog_inc = wdog + 16'd1;
  assign wd_hit   = (wdog_inc == TO_LIM);
`else
  assign orphan = 1'b0;
  assign wd_hit = 1'b0;
`endif

  // arbitration: m1 wins if alone, or on a tie when m0 was served last
  logic arb_sel, arb_req, cmd_open, cmd_acc;
  assign arb_sel  = m_cmd_valid[1] & (~m_cmd_valid[0] | ~last_grant);
  assign arb_req  = |m_cmd_valid;
  assign cmd_open = rst_n & (state == IDLE) & ~orphan;
  assign cmd_acc  = cmd_open & arb_req;
  assign m_cmd_ready[0] = cmd_open & m_cmd_valid[0] & ~arb_sel;
  assign m_cmd_ready[1] = cmd_open & arb_sel;

  logic rsp_hs, done;
  assign rsp_hs = s_icb_rsp_valid & s_icb_rsp_ready;

  // next state, slave handshake signals and response steering
  always_comb begin
    state_nxt       = state;
    s_icb_cmd_valid = 1'b0;
    s_icb_rsp_ready = 1'b0;
    m_rsp_valid     = '0;
    m_rsp_rdata     = '0;
    m_rsp_err       = '0;
    done            = 1'b0;
    case (state)
      IDLE: if (cmd_acc) state_nxt = CMD;
      CMD: begin
        s_icb_cmd_valid = 1'b1;
        if (s_icb_cmd_ready) state_nxt = RSP;
`ifdef ADD_ARB_TIMEOUT_EN
        else if (wd_hit)     state_nxt = ERR;
`endif
      end
      RSP: begin
        s_icb_rsp_ready    = m_rsp_ready[grant];
        m_rsp_valid[grant] = s_icb_rsp_valid;
        m_rsp_rdata[grant] = s_icb_rsp_rdata;
        m_rsp_err[grant]   = s_icb_rsp_err;
        if (rsp_hs) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
`ifdef ADD_ARB_TIMEOUT_EN
        else if (wd_hit) state_nxt = ERR;
`endif
      end
`ifdef ADD_ARB_TIMEOUT_EN
      ERR: begin
        m_rsp_valid[grant] = 1'b1;
        m_rsp_err[grant]   = 1'b1;
        if (m_rsp_ready[grant]) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // a late slave response belonging to a timed-out transaction is swallowed
    if (orphan) s_icb_rsp_ready = 1'b1;
  end

  // state, grant bookkeeping and command latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_read   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        grant     <= arb_sel;
        lat_read  <= m_cmd_read[arb_sel];
        lat_addr  <= m_cmd_addr[arb_sel];
        lat_wdata <= m_cmd_wdata[arb_sel];
        lat_wmask <= m_cmd_wmask[arb_sel];
      end
      if (done) last_grant <= grant;
    end
  end

`ifdef ADD_ARB_TIMEOUT_EN
  // watchdog: restarts on each new command, advances on every stalled CMD/RSP cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog   <= '0;
      orphan <= 1'b0;
    end else begin
      if (cmd_acc)
        wdog <= '0;
      else if ((state == CMD && !s_icb_cmd_ready) || (state == RSP && !rsp_hs))
        wdog <= wdog_inc;
      if (state == RSP && state_nxt == ERR)
        orphan <= 1'b1;
      else if (orphan && s_icb_rsp_valid)
        orphan <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_add_icb_arbiter.sv
// Directed bench for add_icb_arbiter. The slave is driven by hand from the stimulus.
module tb_add_icb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [AW-1:0] m0_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata;
  logic [3:0]    m0_cmd_wmask;
  logic          m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [DW-1:0] m0_rsp_rdata;
  logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [AW-1:0] m1_cmd_addr;
  logic [DW-1:0] m1_cmd_wdata;
  logic [3:0]    m1_cmd_wmask;
  logic          m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [DW-1:0] m1_rsp_rdata;
  logic          s_cmd_valid, s_cmd_ready, s_cmd_read;
  logic [AW-1:0] s_cmd_addr;
  logic [DW-1:0] s_cmd_wdata;
  logic [3:0]    s_cmd_wmask;
  logic          s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [DW-1:0] s_rsp_rdata;

  add_icb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_cmd_valid), .m0_icb_cmd_ready(m0_cmd_ready),
    .m0_icb_cmd_read(m0_cmd_read), .m0_icb_cmd_addr(m0_cmd_addr),
    .m0_icb_cmd_wdata(m0_cmd_wdata), .m0_icb_cmd_wmask(m0_cmd_wmask),
    .m0_icb_rsp_valid(m0_rsp_valid), .m0_icb_rsp_ready(m0_rsp_ready),
    .m0_icb_rsp_rdata(m0_rsp_rdata), .m0_icb_rsp_err(m0_rsp_err),
    .m1_icb_cmd_valid(m1_cmd_valid), .m1_icb_cmd_ready(m1_cmd_ready),
    .m1_icb_cmd_read(m1_cmd_read), .m1_icb_cmd_addr(m1_cmd_addr),
    .m1_icb_cmd_wdata(m1_cmd_wdata), .m1_icb_cmd_wmask(m1_cmd_wmask),
    .m1_icb_rsp_valid(m1_rsp_valid), .m1_icb_rsp_ready(m1_rsp_ready),
    .m1_icb_rsp_rdata(m1_rsp_rdata), .m1_icb_rsp_err(m1_rsp_err),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready),
    .s_icb_cmd_read(s_cmd_read), .s_icb_cmd_addr(s_cmd_addr),
    .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_cmd_wmask(s_cmd_wmask),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_ready(s_rsp_ready),
    .s_icb_rsp_rdata(s_rsp_rdata), .s_icb_rsp_err(s_rsp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_wmask = 0;
    m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_wmask = 0;
    m0_rsp_ready = 0; m1_rsp_ready = 0;
    s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    step(); step();

    // reset state
    chk("rst_m0_cmd_ready", m0_cmd_ready, 0);
    chk("rst_m1_cmd_ready", m1_cmd_ready, 0);
    chk("rst_s_cmd_valid", s_cmd_valid, 0);
    chk("rst_s_rsp_ready", s_rsp_ready, 0);
    chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
    chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
    chk("rst_s_cmd_addr", s_cmd_addr, 0);
    rst_n = 1'b1;
    step();

    // 1: lone m0 write addr 0x0 wdata 0x5
    m0_cmd_valid = 1; m0_cmd_read = 0; m0_cmd_addr = 32'h0; m0_cmd_wdata = 32'h5; m0_cmd_wmask = 4'hf;
    #1;
    chk("t1_m0_ready", m0_cmd_ready, 1);
    chk("t1_m1_ready", m1_cmd_ready, 0);
    chk("t1_s_valid_idle", s_cmd_valid, 0);
    step();
    m0_cmd_valid = 0; m0_cmd_wdata = 32'hdead;
    #1;
    chk("t1_s_valid", s_cmd_valid, 1);
    chk("t1_s_read", s_cmd_read, 0);
    chk("t1_s_addr", s_cmd_addr, 32'h0);
    chk("t1_s_wdata", s_cmd_wdata, 32'h5);
    chk("t1_s_wmask", s_cmd_wmask, 4'hf);
    s_cmd_ready = 1;
    step();
    s_cmd_ready = 0; s_rsp_valid = 1; s_rsp_rdata = 32'h0; s_rsp_err = 0; m0_rsp_ready = 1;
    #1;
    chk("t1_s_valid_rsp", s_cmd_valid, 0);
    chk("t1_m0_rsp_valid", m0_rsp_valid, 1);
    chk("t1_m0_rsp_err", m0_rsp_err, 0);
    chk("t1_m1_rsp_valid", m1_rsp_valid, 0);
    chk("t1_s_rsp_ready", s_rsp_ready, 1);
    step();
    s_rsp_valid = 0; m0_rsp_ready = 0;
    #1;
    chk("t1_back_idle", m0_rsp_valid, 0);

    // 2: both request after reset -> m0,m1,m0,m1, one accept every 3 cycles
    rst_n = 0;
    step();
    rst_n = 1;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h4;
    m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 32'h8;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_m1;
      exp_m1 = logic'(i % 2);
      #1;
      chk("t2_m0_ready", m0_cmd_ready, !exp_m1);
      chk("t2_m1_ready", m1_cmd_ready, exp_m1);
      step();
      chk("t2_cmd_no_accept", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
      chk("t2_s_addr", s_cmd_addr, exp_m1 ? 32'h8 : 32'h4);
      s_cmd_ready = 1;
      step();
      s_cmd_ready = 0; s_rsp_valid = 1; s_rsp_rdata = 32'h100 + i;
      #1;
      chk("t2_m0_rsp_valid", m0_rsp_valid, !exp_m1);
      chk("t2_m1_rsp_valid", m1_rsp_valid, exp_m1);
      chk("t2_m0_rdata", m0_rsp_rdata, exp_m1 ? 32'h0 : 32'h100 + i);
      chk("t2_m1_rdata", m1_rsp_rdata, exp_m1 ? 32'h100 + i : 32'h0);
      chk("t2_rsp_no_accept", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
      step();
      s_rsp_valid = 0;
    end
    m0_cmd_valid = 0; m1_cmd_valid = 0;

    // 3: m1 reads SUM, m1 stalls its response 5 cycles while m0 requests
    m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 32'hC; m1_rsp_ready = 0;
    #1;
    chk("t3_m1_ready", m1_cmd_ready, 1);
    step();
    m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_read = 0; m0_cmd_addr = 32'h4;
    m0_cmd_wdata = 32'hAA; m0_cmd_wmask = 4'h3;
    #1;
    chk("t3_s_read", s_cmd_read, 1);
    chk("t3_s_addr", s_cmd_addr, 32'hC);
    chk("t3_m0_ready_cmd", m0_cmd_ready, 0);
    s_cmd_ready = 1;
    step();
    s_cmd_ready = 0; s_rsp_valid = 1; s_rsp_rdata = 32'h0000_000C;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_m1_rsp_valid", m1_rsp_valid, 1);
      chk("t3_m1_rdata", m1_rsp_rdata, 32'hC);
      chk("t3_s_rsp_ready", s_rsp_ready, 0);
      chk("t3_m0_ready", m0_cmd_ready, 0);
      step();
    end
    m1_rsp_ready = 1;
    #1;
    chk("t3_s_rsp_ready_rel", s_rsp_ready, 1);
    step();
    s_rsp_valid = 0; m1_rsp_ready = 0;

    // 4: m0 (served because m1 went last) waits 10 cycles on slave cmd_ready
    m1_cmd_valid = 1; m1_cmd_addr = 32'h10;
    #1;
    chk("t4_m0_ready", m0_cmd_ready, 1);
    chk("t4_m1_ready", m1_cmd_ready, 0);
    step();
    m0_cmd_addr = 32'hFF; m0_cmd_wdata = 32'h1234;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_s_valid", s_cmd_valid, 1);
      chk("t4_s_addr", s_cmd_addr, 32'h4);
      chk("t4_s_wdata", s_cmd_wdata, 32'hAA);
      chk("t4_s_wmask", s_cmd_wmask, 4'h3);
      chk("t4_no_accept", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
      step();
    end
    m0_cmd_valid = 0; s_cmd_ready = 1;
    step();
    s_cmd_ready = 0; s_rsp_valid = 1; s_rsp_err = 1; s_rsp_rdata = 32'h5A; m0_rsp_ready = 1;
    #1;
    chk("t4_m0_rsp_err", m0_rsp_err, 1);
    chk("t4_m1_rsp_err", m1_rsp_err, 0);
    step();
    s_rsp_valid = 0; s_rsp_err = 0;

    // 6: reset during RSP of an m1 transaction (m0 went last, so m1 wins)
    m0_cmd_valid = 1;
    #1;
    chk("t6_m1_grant", m1_cmd_ready, 1);
    step();
    s_cmd_ready = 1;
    step();
    s_cmd_ready = 0; m1_rsp_ready = 0;
    #1;
    chk("t6_in_rsp", s_rsp_ready, 0);
    rst_n = 0;
    step();
    s_rsp_valid = 1; m1_rsp_ready = 1;
    #1;
    chk("t6_s_valid", s_cmd_valid, 0);
    chk("t6_m1_rsp_valid", m1_rsp_valid, 0);
    chk("t6_m0_rsp_valid", m0_rsp_valid, 0);
    chk("t6_cmd_ready", {m0_cmd_ready, m1_cmd_ready}, 2'b00);
    s_rsp_valid = 0; m1_rsp_ready = 0;
    rst_n = 1;
    #1;
    chk("t6_m0_first", m0_cmd_ready, 1);
    chk("t6_m1_wait", m1_cmd_ready, 0);
    step();
    m0_cmd_valid = 0; m1_cmd_valid = 0;
    s_cmd_ready = 1;
    step();
    s_cmd_ready = 0; s_rsp_valid = 1; m0_rsp_ready = 1;
    step();
    s_rsp_valid = 0; m0_rsp_ready = 0;

`ifdef ADD_ARB_TIMEOUT_EN
    // 5: slave never responds; timeout at 8 stalled RSP cycles, late response dropped
    m0_cmd_valid = 1; m0_rsp_ready = 0;
    step();
    m0_cmd_valid = 0; s_cmd_ready = 1;
    step();
    s_cmd_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_wait_rsp", m0_rsp_valid, 0);
      step();
    end
    chk("t5_err_valid", m0_rsp_valid, 1);
    chk("t5_err_flag", m0_rsp_err, 1);
    chk("t5_err_rdata", m0_rsp_rdata, 0);
    m0_rsp_ready = 1;
    step();
    m0_rsp_ready = 0; m1_cmd_valid = 1;
    #1;
    chk("t5_orphan_block", m1_cmd_ready, 0);
    s_rsp_valid = 1; s_rsp_rdata = 32'h77;
    #1;
    chk("t5_orphan_consume", s_rsp_ready, 1);
    chk("t5_no_forward", m1_rsp_valid, 0);
    step();
    s_rsp_valid = 0;
    #1;
    chk("t5_grant_after", m1_cmd_ready, 1);
    m1_cmd_valid = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
